// File: rtl/sequence_collector.sv
// Trigger-paced collector: strobes TRIGGER toward a serializing peer, captures one
// value per high phase, and publishes the assembled frame with a one-cycle VALID_OUT.
module sequence_collector #(
  parameter int NUM_VALUES          = 4,
  parameter int WIDTH               = 8,
  parameter int TRIGGER_HIGH_CYCLES = 2,
  parameter int TRIGGER_LOW_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES      = 16
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        START,
  output logic                        BUSY,
  output logic                        TRIGGER,
  input  logic [WIDTH-1:0]            VALUE_IN,
  input  logic                        VALID_IN,
  output logic [NUM_VALUES*WIDTH-1:0] VALUES_OUT,
  output logic                        VALID_OUT,
  output logic                        TIMEOUT,
  output logic [1:0]                  DBG_STATE
);

  localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_TRIG_HIGH = 2'd1,
    S_TRIG_LOW  = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                        r_state, w_state_nxt;
  logic [IDX_W-1:0]              r_idx, w_idx_nxt;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                          r_got, w_got_nxt;
  logic [NUM_VALUES*WIDTH-1:0]   r_shadow, w_shadow_nxt;
  logic [NUM_VALUES*WIDTH-1:0]   r_values, w_values_nxt;
  logic                          r_trigger, w_trigger_nxt;
  logic                          r_busy, w_busy_nxt;
  logic                          r_valid_out, w_valid_out_nxt;
  logic                          r_timeout, w_timeout_nxt;

  // Saturate at the abort threshold so a long phase can never wrap back to zero.
  assign w_cnt_inc = (r_cnt >= CNT_W'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_got       <= 1'b0;
      r_shadow    <= '0;
      r_values    <= '0;
      r_trigger   <= 1'b0;
      r_busy      <= 1'b0;
      r_valid_out <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_got       <= w_got_nxt;
      r_shadow    <= w_shadow_nxt;
      r_values    <= w_values_nxt;
      r_trigger   <= w_trigger_nxt;
      r_busy      <= w_busy_nxt;
      r_valid_out <= w_valid_out_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_got_nxt       = r_got;
    w_shadow_nxt    = r_shadow;
    w_values_nxt    = r_values;
    w_trigger_nxt   = r_trigger;
    w_busy_nxt      = r_busy;
    w_valid_out_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_trigger_nxt = 1'b0;
        if (START) begin
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_got_nxt     = 1'b0;
          w_trigger_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_TRIG_HIGH;
        end
      end
      S_TRIG_HIGH: begin
        w_cnt_nxt = w_cnt_inc;
        if (VALID_IN && !r_got) begin
          w_shadow_nxt[r_idx*WIDTH +: WIDTH] = VALUE_IN;
          w_got_nxt = 1'b1;
        end
        // A capture in this very cycle already counts toward leaving the phase.
        if ((r_got || VALID_IN) && (w_cnt_inc >= CNT_W'(TRIGGER_HIGH_CYCLES))) begin
          w_cnt_nxt     = '0;
          w_trigger_nxt = 1'b0;
          w_state_nxt   = S_TRIG_LOW;
        end else if (w_cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
          w_cnt_nxt     = '0;
          w_trigger_nxt = 1'b0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      S_TRIG_LOW: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc >= CNT_W'(TRIGGER_LOW_CYCLES)) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_W'(NUM_VALUES - 1)) begin
            w_values_nxt    = r_shadow;
            w_valid_out_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_idx_nxt     = r_idx + IDX_W'(1);
            w_got_nxt     = 1'b0;
            w_trigger_nxt = 1'b1;
            w_state_nxt   = S_TRIG_HIGH;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign BUSY       = r_busy;
  assign TRIGGER    = r_trigger;
  assign VALUES_OUT = r_values;
  assign VALID_OUT  = r_valid_out;
  assign TIMEOUT    = r_timeout;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_sequence_collector.sv
// Bench for sequence_collector: a per-cycle expected timeline is built from frame
// descriptions (start cycle, peer response delay per slot, values), then compared every cycle.
module tb_sequence_collector;
  localparam int NV    = 4;
  localparam int W     = 8;
  localparam int H     = 2;
  localparam int L     = 2;
  localparam int TO    = 16;
  localparam int MAXC  = 224;
  localparam int END_C = 212;

  logic clk = 1'b0;
  logic rstn, start, valid_in;
  logic [W-1:0] value_in;
  logic busy, trig, vout, tout;
  logic [NV*W-1:0] values;
  logic [1:0] dbg;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  // expected outputs per cycle
  logic          exp_trig [MAXC];
  logic          exp_busy [MAXC];
  logic          exp_vout [MAXC];
  logic          exp_tout [MAXC];
  logic [31:0]   exp_vals [MAXC];
  // input drive per cycle
  logic          drv_rstn [MAXC];
  logic          drv_start[MAXC];
  logic          drv_valid[MAXC];
  logic [W-1:0]  drv_value[MAXC];
  // observed outputs per cycle
  logic          obs_trig [MAXC];
  logic          obs_busy [MAXC];
  logic          obs_vout [MAXC];
  logic          obs_tout [MAXC];
  logic [31:0]   obs_vals [MAXC];
  logic [1:0]    obs_dbg  [MAXC];

  always #5 clk = ~clk;

  sequence_collector #(
    .NUM_VALUES(NV), .WIDTH(W), .TRIGGER_HIGH_CYCLES(H),
    .TRIGGER_LOW_CYCLES(L), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RSTN(rstn), .START(start), .BUSY(busy), .TRIGGER(trig),
    .VALUE_IN(value_in), .VALID_IN(valid_in), .VALUES_OUT(values),
    .VALID_OUT(vout), .TIMEOUT(tout), .DBG_STATE(dbg)
  );

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual %h required %h", name, c, act, exp);
    end
  endtask

  // Frame timeline: high phase lasts max(H, delay+1) cycles, low phase L cycles,
  // then one DONE cycle carrying VALID_OUT and the new frame. A silent slot holds
  // TRIGGER high TO cycles and then pulses TIMEOUT with the block idle.
  task automatic build_frame(input int s, input logic [15:0] dly, input logic [31:0] vals,
                             input int silent_slot, input bit dup0, input bit ff_low,
                             output int end_c);
    int t, hl, d;
    drv_start[s] = 1'b1;
    t = s + 1;
    end_c = 0;
    for (int k = 0; k < NV; k++) begin
      if (k == silent_slot) begin
        for (int c = t; c < t + TO; c++) begin
          exp_trig[c] = 1'b1;
          exp_busy[c] = 1'b1;
        end
        exp_tout[t + TO] = 1'b1;
        end_c = t + TO;
        return;
      end
      d  = int'(dly[k*4 +: 4]);
      hl = (d + 1 > H) ? d + 1 : H;
      for (int c = t; c < t + hl; c++) begin
        exp_trig[c] = 1'b1;
        exp_busy[c] = 1'b1;
      end
      drv_valid[t + d] = 1'b1;
      drv_value[t + d] = vals[k*8 +: 8];
      if (dup0 && k == 0) begin
        drv_valid[t + d + 1] = 1'b1;
        drv_value[t + d + 1] = 8'hBB;
      end
      for (int c = t + hl; c < t + hl + L; c++) begin
        exp_busy[c] = 1'b1;
        if (ff_low) begin
          drv_valid[c] = 1'b1;
          drv_value[c] = 8'hFF;
        end
      end
      t = t + hl + L;
    end
    exp_busy[t] = 1'b1;
    exp_vout[t] = 1'b1;
    for (int c = t; c < MAXC; c++) exp_vals[c] = vals;
    end_c = t;
  endtask

  // Reset sampled from cycle r0+1: everything idles and the frame register clears.
  task automatic apply_reset(input int r0, input int r1, input int clr_end);
    for (int c = r0; c <= r1; c++) drv_rstn[c] = 1'b0;
    for (int c = r0 + 1; c <= clr_end; c++) begin
      exp_trig[c] = 1'b0;
      exp_busy[c] = 1'b0;
      exp_vout[c] = 1'b0;
      exp_tout[c] = 1'b0;
    end
    for (int c = r0 + 1; c < MAXC; c++) exp_vals[c] = '0;
  endtask

  function automatic int rises(input int a, input int b);
    int n = 0;
    for (int c = a + 1; c <= b; c++) if (obs_trig[c] && !obs_trig[c-1]) n++;
    return n;
  endfunction

  function automatic int count_sig(input int sel, input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) begin
      if (sel == 0 && obs_trig[c]) n++;
      if (sel == 1 && obs_vout[c]) n++;
      if (sel == 2 && obs_tout[c]) n++;
    end
    return n;
  endfunction

  task automatic drive(input int c);
    rstn     = drv_rstn[c];
    start    = drv_start[c];
    valid_in = drv_valid[c];
    value_in = drv_value[c];
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < END_C) begin
      obs_trig[cyc] <= trig;
      obs_busy[cyc] <= busy;
      obs_vout[cyc] <= vout;
      obs_tout[cyc] <= tout;
      obs_vals[cyc] <= values;
      obs_dbg[cyc]  <= dbg;
      check("trigger",    cyc, 32'(trig), 32'(exp_trig[cyc]));
      check("busy",       cyc, 32'(busy), 32'(exp_busy[cyc]));
      check("valid_out",  cyc, 32'(vout), 32'(exp_vout[cyc]));
      check("timeout",    cyc, 32'(tout), 32'(exp_tout[cyc]));
      check("values_out", cyc, values,    exp_vals[cyc]);
    end
  end

  initial begin
    int e1, e2, e3, e4, e5, e6, e7;
    for (int c = 0; c < MAXC; c++) begin
      exp_trig[c] = 1'b0; exp_busy[c] = 1'b0; exp_vout[c] = 1'b0; exp_tout[c] = 1'b0;
      exp_vals[c] = '0;
      drv_rstn[c] = 1'b1; drv_start[c] = 1'b0; drv_valid[c] = 1'b0; drv_value[c] = '0;
      obs_trig[c] = 1'b0; obs_busy[c] = 1'b0; obs_vout[c] = 1'b0; obs_tout[c] = 1'b0;
      obs_vals[c] = '0; obs_dbg[c] = '0;
    end
    for (int c = 0; c <= 2; c++) drv_rstn[c] = 1'b0;

    build_frame(5,   16'h3333, 32'h44332211, -1, 1'b0, 1'b0, e1);  // nominal, answer on 4th high cycle
    build_frame(40,  16'h0000, 32'h40302010, -1, 1'b0, 1'b0, e2);  // immediate responder
    build_frame(65,  16'h1110, 32'h040302AA, -1, 1'b1, 1'b0, e3);  // duplicate 0xBB ignored
    build_frame(90,  16'h0000, 32'h00000201,  2, 1'b0, 1'b0, e4);  // silent on slot 2
    build_frame(125, 16'h0000, 32'h74737271, -1, 1'b0, 1'b0, e5);  // cut by reset
    apply_reset(132, 134, e5 + 1);
    build_frame(140, 16'h1111, 32'h5D5C5B5A, -1, 1'b0, 1'b0, e6);
    build_frame(165, 16'h2222, 32'h64636261, -1, 1'b0, 1'b1, e7);  // 0xFF in low phases
    for (int c = 166; c <= e7; c += 2) drv_start[c] = 1'b1;
    drv_valid[e7 + 2] = 1'b1; drv_value[e7 + 2] = 8'hFF;
    drv_valid[e7 + 3] = 1'b1; drv_value[e7 + 3] = 8'hFF;

    drive(0);
    while (cyc < END_C) begin
      @(posedge clk);
      cyc++;
      #1;
      drive(cyc);
    end
    @(negedge clk);

    // hand-computed expectations
    check("nom_rises",       0,  32'(rises(5, 35)),         32'd4);
    check("nom_high_cycles", 0,  32'(count_sig(0, 6, 35)),  32'd16);
    check("nom_frame",       32, obs_vals[32],              32'h44332211);
    check("nom_vout_pulses", 0,  32'(count_sig(1, 5, 38)),  32'd1);
    check("nom_vout_at",     30, 32'(obs_vout[30]),         32'd1);
    check("nom_busy_fall",   31, 32'(obs_busy[31]),         32'd0);
    check("imm_vout_at_18",  57, 32'(obs_vout[57]),         32'd1);
    check("imm_high_cycles", 0,  32'(count_sig(0, 41, 57)), 32'd8);
    check("dup_frame",       84, obs_vals[84],              32'h040302AA);
    check("to_high_run",     0,  32'(count_sig(0, 99, 114)), 32'd16);
    check("to_pulse_at",     115, 32'(obs_tout[115]),       32'd1);
    check("to_pulses",       0,  32'(count_sig(2, 90, 124)), 32'd1);
    check("to_no_vout",      0,  32'(count_sig(1, 90, 124)), 32'd0);
    check("to_state_idle",   116, 32'(obs_dbg[116]),        32'd0);
    check("to_frame_kept",   117, obs_vals[117],            32'h040302AA);
    check("rst_frame_zero",  134, obs_vals[134],            32'h0);
    check("rst_busy",        134, 32'(obs_busy[134]),       32'd0);
    check("rst_state_idle",  134, 32'(obs_dbg[134]),        32'd0);
    check("post_rst_frame",  159, obs_vals[159],            32'h5D5C5B5A);
    check("busy_start_rises", 0, 32'(rises(165, 195)),      32'd4);
    check("busy_start_vout",  0, 32'(count_sig(1, 165, 205)), 32'd1);
    check("ff_frame",        190, obs_vals[190],            32'h64636261);
    check("done_start_idle", 188, 32'(obs_busy[188]),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
